// File: rtl/monitor_stage_param.sv
// Runtime-monitor cluster stage: symbol/stream-reset pipeline plus report capture into sticky flags and a timestamped FIFO.
// Define MON_REPORT_COUNT_EN to add per-report saturating counters on rpt_count.

module monitor_stage_slot #(
   parameter int TS_W  = 16,
   parameter int CNT_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cap,
   input  logic            push_hit,
   input  logic            clr,
   input  logic [TS_W-1:0] ts,
   output logic            sticky,
   output logic            pending,
   output logic [TS_W-1:0] ts_reg,
   output logic            coalesce
`ifdef MON_REPORT_COUNT_EN
  ,output logic [CNT_W-1:0] cnt
`endif
);
   // A capture on a slot being pushed this cycle is a fresh event, not a coalesce.
   assign coalesce = cap && pending && !push_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sticky  <= 1'b0;
         pending <= 1'b0;
         ts_reg  <= '0;
      end else begin
         if (cap)      sticky <= 1'b1;
         else if (clr) sticky <= 1'b0;
         if (cap && (!pending || push_hit)) begin
            pending <= 1'b1;
            ts_reg  <= ts;
         end else if (push_hit) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef MON_REPORT_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   cnt <= '0;
      else if (clr)                cnt <= cap ? CNT_W'(1) : '0;
      else if (cap && cnt != '1)   cnt <= cnt + CNT_W'(1);
   end
`endif
endmodule

module monitor_stage_param #(
   parameter int SYM_W       = 8,
   parameter int PIPE_DEPTH  = 1,
   parameter int NUM_REPORTS = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int TS_W        = 16,
   parameter int CNT_W       = 8,
   localparam int IDX_W      = $clog2(NUM_REPORTS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   stream_reset,
   input  logic [SYM_W-1:0]       top_symbols,
   input  logic [NUM_REPORTS-1:0] report_in,
   output logic [SYM_W-1:0]       out_symbols,
   output logic                   out_reset,
   output logic [NUM_REPORTS-1:0] sticky,
   input  logic [NUM_REPORTS-1:0] sticky_clr,
   output logic                   rpt_valid,
   input  logic                   rpt_ready,
   output logic [IDX_W-1:0]       rpt_index,
   output logic [TS_W-1:0]        rpt_ts,
   output logic                   overflow,
   input  logic                   ovf_clr
`ifdef MON_REPORT_COUNT_EN
  ,output logic [NUM_REPORTS*CNT_W-1:0] rpt_count
`endif
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int E_W = IDX_W + TS_W;

   logic [PIPE_DEPTH-1:0][SYM_W-1:0] sym_pipe;
   logic [PIPE_DEPTH-1:0]            rst_pipe;
   logic [TS_W-1:0]                  ts;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sym_pipe <= '0;
         rst_pipe <= '0;
         ts       <= '0;
      end else if (run) begin
         sym_pipe[0] <= top_symbols;
         rst_pipe[0] <= stream_reset;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            sym_pipe[k] <= sym_pipe[k-1];
            rst_pipe[k] <= rst_pipe[k-1];
         end
         ts <= ts + TS_W'(1);
      end
   end

   assign out_symbols = sym_pipe[PIPE_DEPTH-1];
   assign out_reset   = rst_pipe[PIPE_DEPTH-1];

   logic [NUM_REPORTS-1:0]            pending, coalesce;
   logic [NUM_REPORTS-1:0][TS_W-1:0]  ts_reg;
   logic [IDX_W-1:0]                  push_idx;
   logic                              push_en, pop, full, empty;
   logic [AW:0]                       wr_ptr, rd_ptr;
   logic [FIFO_DEPTH-1:0][E_W-1:0]    mem;

   always_comb begin
      push_idx = '0;
      for (int i = NUM_REPORTS - 1; i >= 0; i--)
         if (pending[i]) push_idx = IDX_W'(i);
   end

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = !empty && rpt_ready;
   // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
   assign push_en = (|pending) && (!full || pop);

   genvar g;
   generate
      for (g = 0; g < NUM_REPORTS; g++) begin : g_slot
         monitor_stage_slot #(.TS_W(TS_W), .CNT_W(CNT_W)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .cap      (run && report_in[g]),
            .push_hit (push_en && (push_idx == IDX_W'(g))),
            .clr      (sticky_clr[g]),
            .ts       (ts),
            .sticky   (sticky[g]),
            .pending  (pending[g]),
            .ts_reg   (ts_reg[g]),
            .coalesce (coalesce[g])
`ifdef MON_REPORT_COUNT_EN
           ,.cnt      (rpt_count[g*CNT_W +: CNT_W])
`endif
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
         if (|coalesce)    overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk)
      if (push_en) mem[wr_ptr[AW-1:0]] <= {push_idx, ts_reg[push_idx]};

   assign rpt_valid            = !empty;
   assign {rpt_index, rpt_ts}  = mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_monitor_stage_param.sv
// Bench for monitor_stage_param: pipeline vector table, scoreboarded report FIFO, corner-case sequences.
module tb_monitor_stage_param;
   localparam int NR = 8;

   logic          clk, reset, run, stream_reset, rpt_ready, ovf_clr;
   logic [7:0]    top_symbols, out_symbols;
   logic [NR-1:0] report_in, sticky, sticky_clr;
   logic          out_reset, rpt_valid, overflow;
   logic [2:0]    rpt_index;
   logic [15:0]   rpt_ts;
`ifdef MON_REPORT_COUNT_EN
   logic [NR*2-1:0] rpt_count;
`endif

   monitor_stage_param #(.SYM_W(8), .PIPE_DEPTH(2), .NUM_REPORTS(NR), .FIFO_DEPTH(4),
                         .TS_W(16), .CNT_W(2)) dut (
      .clk(clk), .reset(reset), .run(run), .stream_reset(stream_reset),
      .top_symbols(top_symbols), .report_in(report_in), .out_symbols(out_symbols),
      .out_reset(out_reset), .sticky(sticky), .sticky_clr(sticky_clr),
      .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_index(rpt_index),
      .rpt_ts(rpt_ts), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef MON_REPORT_COUNT_EN
     ,.rpt_count(rpt_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [2:0] idx; logic [15:0] ts; } ent_t;
   typedef struct { logic run; logic sr; logic [7:0] sym; logic [7:0] exp_sym; logic exp_rst; } pvec_t;

   ent_t        exp_q[$];
   pvec_t       pv[8];
   int          total = 0, bad = 0;
   logic [15:0] ts_m = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (run) ts_m++;
      #1;
   endtask

   task automatic expect_ent(input int idx, input logic [15:0] t);
      ent_t e;
      e.idx = 3'(idx);
      e.ts  = t;
      exp_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      tick();
      chk("drain_valid", rpt_valid, 0);
   endtask

   // Scoreboard: every completed handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && rpt_valid && rpt_ready) begin
         ent_t e;
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", {rpt_index, rpt_ts}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("pop_idx", rpt_index, e.idx);
            chk("pop_ts", rpt_ts, e.ts);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      pv[0] = '{1, 1, 8'h11, 8'h00, 0};
      pv[1] = '{1, 0, 8'h22, 8'h11, 1};
      pv[2] = '{1, 0, 8'h33, 8'h22, 0};
      pv[3] = '{0, 1, 8'h44, 8'h22, 0};
      pv[4] = '{0, 0, 8'h55, 8'h22, 0};
      pv[5] = '{0, 0, 8'h66, 8'h22, 0};
      pv[6] = '{1, 0, 8'h77, 8'h33, 0};
      pv[7] = '{1, 0, 8'h88, 8'h77, 0};

      reset = 1; run = 0; stream_reset = 0; top_symbols = 0; report_in = 0;
      sticky_clr = 0; rpt_ready = 0; ovf_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sym", out_symbols, 0);
      chk("rst_out_reset", out_reset, 0);
      chk("rst_sticky", sticky, 0);
      chk("rst_valid", rpt_valid, 0);
      chk("rst_ovf", overflow, 0);
      reset = 0;
      ts_m = 0;

      for (int i = 0; i < 8; i++) begin
         run = pv[i].run; stream_reset = pv[i].sr; top_symbols = pv[i].sym;
         tick();
         chk($sformatf("pipe_sym%0d", i), out_symbols, pv[i].exp_sym);
         chk($sformatf("pipe_rst%0d", i), out_reset, pv[i].exp_rst);
      end

      // Simultaneous reports drain lowest index first.
      run = 1; report_in = 8'h85; rpt_ready = 1;
      expect_ent(0, ts_m); expect_ent(2, ts_m); expect_ent(7, ts_m);
      tick();
      report_in = 0; run = 0;
      drain(20);
      chk("sticky_85", sticky, 8'h85);

      // Sticky clear collides with a capture on bit 4: set wins.
      run = 1; report_in = 8'h10; sticky_clr = 8'h95;
      expect_ent(4, ts_m);
      tick();
      run = 0; report_in = 0; sticky_clr = 0;
      chk("sticky_set_wins", sticky, 8'h10);
      drain(20);
      sticky_clr = 8'h10;
      tick();
      sticky_clr = 0;
      chk("sticky_cleared", sticky, 0);

      // Reports are ignored while run=0.
      report_in = 8'h02;
      tick(); tick();
      report_in = 0;
      chk("norun_valid", rpt_valid, 0);
      chk("norun_sticky", sticky, 0);

      // Back-pressure: 4 queued, 2 pending, then drained in order.
      rpt_ready = 0; run = 1;
      for (int b = 0; b < 6; b++) begin
         report_in = NR'(1) << b;
         expect_ent(b, ts_m);
         tick();
      end
      report_in = 0; run = 0;
      tick(); tick();
      chk("bp_valid", rpt_valid, 1);
      chk("bp_head_idx", rpt_index, exp_q[0].idx);
      chk("bp_head_ts", rpt_ts, exp_q[0].ts);
      tick();
      chk("bp_hold_idx", rpt_index, exp_q[0].idx);
      chk("bp_hold_ts", rpt_ts, exp_q[0].ts);
      rpt_ready = 1;
      drain(30);
      chk("bp_ovf", overflow, 0);

      // Re-capture of a slot in its push cycle gives a second entry, not a coalesce.
      run = 1; report_in = 8'h40;
      expect_ent(6, ts_m);
      tick();
      expect_ent(6, ts_m);
      tick();
      run = 0; report_in = 0;
      drain(20);
      chk("recap_ovf", overflow, 0);

      // Coalesce against a full FIFO.
      rpt_ready = 0; run = 1;
      for (int k = 0; k < 5; k++) begin
         int b;
         b = (k == 3) ? 4 : (k == 4) ? 3 : k;
         report_in = NR'(1) << b;
         expect_ent(b, ts_m);
         tick();
      end
      report_in = 8'h08;
      tick();
      report_in = 0; run = 0;
      tick();
      chk("coal_ovf", overflow, 1);
      run = 1; report_in = 8'h08; ovf_clr = 1;
      tick();
      chk("coal_ovf_wins", overflow, 1);
      run = 0; report_in = 0;
      tick();
      ovf_clr = 0;
      chk("ovf_cleared", overflow, 0);
      rpt_ready = 1;
      drain(30);

      // Async reset mid-drain.
      rpt_ready = 0; run = 1; top_symbols = 8'h5A; report_in = 8'h01;
      tick();
      report_in = 8'h02;
      tick();
      report_in = 0;
      tick(); tick();
      chk("pre_rst_valid", rpt_valid, 1);
      chk("pre_rst_sym", out_symbols, 8'h5A);
      #2;
      reset = 1;
      #1;
      chk("arst_valid", rpt_valid, 0);
      chk("arst_sticky", sticky, 0);
      chk("arst_sym", out_symbols, 0);
      exp_q.delete();
      ts_m = 0;
      @(negedge clk);
      reset = 0; run = 1; report_in = 8'h20; rpt_ready = 1;
      expect_ent(5, 16'd0);
      tick();
      run = 0; report_in = 0;
      drain(20);

`ifdef MON_REPORT_COUNT_EN
      run = 1; report_in = 8'h02;
      for (int p = 0; p < 5; p++) begin
         expect_ent(1, ts_m);
         tick();
      end
      run = 0; report_in = 0;
      chk("cnt_sat", rpt_count[3:2], 2'd3);
      sticky_clr = 8'h02;
      tick();
      sticky_clr = 0;
      chk("cnt_clr", rpt_count[3:2], 2'd0);
      drain(20);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/monitor_stage_param.md
Name: monitor_stage_param

Overview:
- Parametrised successor to the fixed-width cluster automata stage in the runtime monitor.
- Pipelines the symbol stream and in-band stream reset through PIPE_DEPTH registers toward the next stage.
- Captures report pulses from the stage's automata into sticky flags and a timestamped report FIFO that software or the aggregator drains with a valid/ready handshake.
- Sits between cluster stage N and N+1. The automata instances stay outside; their report outputs feed report_in.

Parameters:
- SYM_W, 8, symbol width in bits.
- PIPE_DEPTH, 1, symbol/stream-reset pipeline registers (1..4).
- NUM_REPORTS, 8, report inputs (2..32).
- FIFO_DEPTH, 4, report FIFO entries (power of 2, >=2).
- TS_W, 16, timestamp width.
- CNT_W, 8, per-report counter width (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- run  in  1  stream advance enable
- stream_reset  in  1  in-band automata reset accompanying top_symbols
- top_symbols  in  SYM_W  incoming symbol
- report_in  in  NUM_REPORTS  automata report pulses, aligned with top_symbols
- out_symbols  out  SYM_W  pipelined symbol
- out_reset  out  1  pipelined stream_reset
- sticky  out  NUM_REPORTS  sticky report flags
- sticky_clr  in  NUM_REPORTS  write-1-to-clear for sticky
- rpt_valid  out  1  FIFO head valid
- rpt_ready  in  1  consumer accepts head
- rpt_index  out  clog2(NUM_REPORTS)  head report index
- rpt_ts  out  TS_W  head capture timestamp
- overflow  out  1  sticky: a report was coalesced
- ovf_clr  in  1  clears overflow
- rpt_count  out  NUM_REPORTS*CNT_W  per-report counters (only with the feature; index i at bits [i*CNT_W +: CNT_W])

Behaviour:
- Reset (async, active-high): all pipeline registers, out_symbols, out_reset, sticky, pending, FIFO pointers, timestamp and overflow go to 0. rpt_valid=0.
- Pipeline: when run=1, stage0 takes top_symbols/stream_reset and each stage k takes stage k-1. When run=0, all stages hold. Latency is PIPE_DEPTH run-cycles. out_* come from the last stage.
- Timestamp ts increments by 1 when run=1 and wraps at 2^TS_W.
- Capture: report_in is sampled only when run=1.
  - For each set bit i: sticky[i]<=1.
  - If pending[i]=0: pending[i]<=1 and ts_reg[i]<=ts (value before increment).
  - If pending[i]=1 and i is not being pushed this cycle: coalesce. ts_reg[i] is kept and overflow<=1.
  - If i is being pushed this cycle: pending[i] stays 1 and ts_reg[i]<=ts (new event). No overflow.
- Push: each cycle, if pending!=0 and the FIFO is not full, push the lowest-index pending bit j as {j, ts_reg[j]} and clear pending[j] (unless re-set as above). At most one push per cycle.
- A push and a pop in the same cycle are legal when the FIFO is full: the pop frees a slot, so the push proceeds.
- Pop: a handshake completes when rpt_valid&&rpt_ready. rpt_index/rpt_ts are stable while rpt_valid&&!rpt_ready.
- rpt_valid = FIFO non-empty, driven from registers (no combinational path from report_in).
- sticky_clr[i] clears sticky[i]. If it coincides with a capture on i, the set wins. ovf_clr behaves the same way: a same-cycle coalesce wins.
- stream_reset does not clear the capture logic. Only reset does.

Optional Feature:
- Macro MON_REPORT_COUNT_EN.
- Defined: per-report saturating CNT_W counter, incremented by each captured report_in[i] (including coalesced ones). Saturates at all-ones. Cleared by sticky_clr[i] (a same-cycle capture loads 1). Exposed on rpt_count.
- Undefined: no counters and no rpt_count port.

Test Plan:
- Pipeline, PIPE_DEPTH=2: run=1, symbols 0x11,0x22,0x33 -> out_symbols 0x11 appears 2 cycles later. Then run=0 for 3 cycles -> outputs hold.
- Simultaneous reports: report_in=8'b1000_0101 at ts=5, rpt_ready=1 -> FIFO entries {0,5},{2,5},{7,5} in that order; sticky=0x85.
- Back-pressure, FIFO_DEPTH=4, rpt_ready=0: 6 distinct single reports -> 4 queued, 2 pending, rpt_valid held. Raise rpt_ready -> 6 entries drained in order. overflow=0.
- Coalesce: report_in[3] at ts=10 and ts=11 while FIFO full -> one entry {3,10}; overflow=1. ovf_clr -> overflow=0.
- Async reset mid-drain: assert reset between clock edges -> rpt_valid, sticky, out_symbols go to 0 immediately; ts restarts at 0 after release.
- With MON_REPORT_COUNT_EN, CNT_W=2: 5 pulses on report_in[1] -> count 3 (saturated). sticky_clr[1] -> count 0.
